comparator_bist: RTL and testbench

COMPARATOR_BIST -- requirements
Module: comparator_bist

---
 rtl/comparator_bist_pkg.sv | 36 +++
 rtl/comparator_bist_lfsr16.sv | 40 ++++
 rtl/comparator_bist.sv | 140 ++++++++++++++
 tb/tb_comparator_bist.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_bist_pkg.sv
// Shared definitions for the comparator BIST: state encoding, LFSR taps,
// directed vectors and the LFSR step function.
package comparator_bist_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRIVE  = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam vec_t DIR_VEC0 = '{a: 16'd10,  b: 16'd20};
  localparam vec_t DIR_VEC1 = '{a: 16'd100, b: 16'd100};
  localparam vec_t DIR_VEC2 = '{a: 16'd110, b: 16'd20};

  localparam logic [9:0] NO_FAIL = 10'h3FF;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/comparator_bist_lfsr16.sv
// 16-bit Fibonacci LFSR; exposes current state and a one-step lookahead.
// A step advances the register by two positions so both outputs are fresh next time.
module lfsr16
  import comparator_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o,
  output logic [15:0] peek_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  assign state_o = state_q;
  assign peek_o  = lfsr_next(state_q);

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = lfsr_next(peek_o);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/comparator_bist.sv
// BIST engine for an external 16-bit magnitude comparator: drive, settle a cycle, check.
// Each vector takes 3 cycles; done pulses in the cycle after the last check. No backpressure.
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int          N_VECTORS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] a,
  output logic [15:0] b,
  input  logic        equal,
  input  logic        greaterthan,
  input  logic        lessthan,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [9:0]  first_fail_idx
);

  localparam logic [9:0] LAST_IDX = 10'(N_VECTORS - 1);

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  flags_t      flags_q, flags_d;
  logic [7:0]  fail_cnt_q, fail_cnt_d;
  logic [9:0]  first_fail_q, first_fail_d;
  logic        pass_q, pass_d;

  logic        lfsr_load, lfsr_step;
  logic [15:0] lfsr_state, lfsr_peek;
  logic [16:0] diff;
  flags_t      exp_flags;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (LFSR_SEED),
    .state_o (lfsr_state),
    .peek_o  (lfsr_peek)
  );

  // Borrow out of the widened subtraction is the unsigned a<b indication.
  assign diff         = {1'b0, a_q} - {1'b0, b_q};
  assign exp_flags.eq = (diff == 17'd0);
  assign exp_flags.lt = diff[16];
  assign exp_flags.gt = ~exp_flags.eq & ~exp_flags.lt;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    flags_d      = flags_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          idx_d        = 10'd0;
          fail_cnt_d   = 8'd0;
          first_fail_d = NO_FAIL;
          pass_d       = 1'b0;
          lfsr_load    = 1'b1;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SAMPLE;
        case (idx_q)
          10'd0:   {a_d, b_d} = DIR_VEC0;
          10'd1:   {a_d, b_d} = DIR_VEC1;
          10'd2:   {a_d, b_d} = DIR_VEC2;
          default: begin
            a_d       = lfsr_state;
            b_d       = lfsr_peek;
            lfsr_step = 1'b1;
          end
        endcase
      end
      ST_SAMPLE: begin
        state_d = ST_CHECK;
        flags_d = '{eq: equal, gt: greaterthan, lt: lessthan};
      end
      ST_CHECK: begin
        if (flags_q != exp_flags) begin
          if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          if (first_fail_q == NO_FAIL) first_fail_d = idx_q;
        end
        idx_d   = idx_q + 10'd1;
        state_d = (idx_q < LAST_IDX) ? ST_DRIVE : ST_DONE;
      end
      ST_DONE: begin
        pass_d  = (fail_cnt_q == 8'd0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 10'd0;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      flags_q      <= '0;
      fail_cnt_q   <= 8'd0;
      first_fail_q <= NO_FAIL;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      flags_q      <= flags_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_cnt_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench for comparator_bist: three instances (N=16, 3, 300) each driven by a comparator model with a selectable fault.
// Cycle 1 is the cycle following the clock edge that samples start.
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start16, start3, start300;
  int   mode16;

  logic [15:0] a16, b16, a3, b3, a300, b300;
  logic        eq16, gt16, lt16, eq3, gt3, lt3, eq300, gt300, lt300;
  logic        busy16, done16, pass16, busy3, done3, pass3, busy300, done300, pass300;
  logic [7:0]  fc16, fc3, fc300;
  logic [9:0]  ffi16, ffi3, ffi300;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_a [16];
  logic [15:0] exp_b [16];
  logic [15:0] seq_a [16];
  logic [15:0] seq_b [16];

  // mode 0 ideal, 1 greaterthan stuck 0, 2 all flags stuck 0, 3 equal also high on vector (10,20)
  function automatic logic [2:0] cmp_model(input logic [15:0] x, input logic [15:0] y, input int mode);
    logic eq, gt, lt;
    eq = (x == y);
    gt = (x > y);
    lt = (x < y);
    if (mode == 1) gt = 1'b0;
    if (mode == 2) begin eq = 1'b0; gt = 1'b0; lt = 1'b0; end
    if (mode == 3 && x == 16'd10 && y == 16'd20) eq = 1'b1;
    return {eq, gt, lt};
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign {eq16, gt16, lt16}    = cmp_model(a16, b16, mode16);
  assign {eq3, gt3, lt3}       = cmp_model(a3, b3, 1);
  assign {eq300, gt300, lt300} = cmp_model(a300, b300, 2);

  comparator_bist #(.N_VECTORS(16), .LFSR_SEED(16'hACE1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .equal(eq16), .greaterthan(gt16), .lessthan(lt16),
    .busy(busy16), .done(done16), .pass(pass16), .fail_count(fc16), .first_fail_idx(ffi16));

  comparator_bist #(.N_VECTORS(3), .LFSR_SEED(16'hACE1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .equal(eq3), .greaterthan(gt3), .lessthan(lt3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3), .first_fail_idx(ffi3));

  comparator_bist #(.N_VECTORS(300), .LFSR_SEED(16'hACE1)) u_dut300 (
    .clk(clk), .rst_n(rst_n), .start(start300), .a(a300), .b(b300),
    .equal(eq300), .greaterthan(gt300), .lessthan(lt300),
    .busy(busy300), .done(done300), .pass(pass300), .fail_count(fc300), .first_fail_idx(ffi300));

  // Pulses start16, then watches 60 cycles: records a/b at each vector's check cycle,
  // optionally re-pulses start at poke_cyc or drops reset at rst_cyc.
  task automatic run16(input int poke_cyc, input int rst_cyc, output int done_cyc, output int pulses);
    done_cyc = -1;
    pulses   = 0;
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start16 = (cyc == poke_cyc);
      if (cyc % 3 == 0 && cyc <= 48) begin
        seq_a[cyc/3 - 1] = a16;
        seq_b[cyc/3 - 1] = b16;
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      if (done16 === 1'b1) begin
        pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    start16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start16 = 1'b0; start3 = 1'b0; start300 = 1'b0; mode16 = 0;
    repeat (3) @(negedge clk);
    tests++; if (busy16 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy16); end
    tests++; if (done16 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done16); end
    tests++; if (pass16 !== 1'b0) begin fails++; $display("FAIL reset_pass: got %b expected 0", pass16); end
    tests++; if (fc16 !== 8'd0) begin fails++; $display("FAIL reset_fail_count: got %0d expected 0", fc16); end
    tests++; if (ffi16 !== 10'h3FF) begin fails++; $display("FAIL reset_first_fail: got %0h expected 3ff", ffi16); end
    tests++; if (a16 !== 16'd0 || b16 !== 16'd0) begin fails++; $display("FAIL reset_ab: got %0h/%0h expected 0/0", a16, b16); end
  endtask

  task automatic test_first_start();
    int seen;
    seen = -1;
    @(negedge clk); rst_n = 1'b1; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    tests++; if (busy16 !== 1'b1) begin fails++; $display("FAIL first_start_busy: got %b expected 1", busy16); end
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done16 === 1'b1 && seen < 0) seen = cyc;
    end
    tests++; if (seen !== 49) begin fails++; $display("FAIL first_start_done: got cycle %0d expected 49", seen); end
  endtask

  task automatic test_ideal_run();
    int dc, p, bad;
    mode16 = 0;
    run16(0, 0, dc, p);
    bad = 0;
    for (int k = 0; k < 16; k++) if (seq_a[k] !== exp_a[k] || seq_b[k] !== exp_b[k]) bad++;
    tests++; if (dc !== 49) begin fails++; $display("FAIL ideal_done_cycle: got %0d expected 49", dc); end
    tests++; if (p !== 1) begin fails++; $display("FAIL ideal_done_pulses: got %0d expected 1", p); end
    tests++; if (pass16 !== 1'b1) begin fails++; $display("FAIL ideal_pass: got %b expected 1", pass16); end
    tests++; if (fc16 !== 8'd0) begin fails++; $display("FAIL ideal_fail_count: got %0d expected 0", fc16); end
    tests++; if (ffi16 !== 10'h3FF) begin fails++; $display("FAIL ideal_first_fail: got %0h expected 3ff", ffi16); end
    tests++; if (busy16 !== 1'b0) begin fails++; $display("FAIL ideal_idle_busy: got %b expected 0", busy16); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL ideal_sequence: got %0d bad vectors expected 0", bad); end
    tests++; if (seq_a[0] !== 16'd10 || seq_b[0] !== 16'd20) begin fails++; $display("FAIL vec0: got %0d/%0d expected 10/20", seq_a[0], seq_b[0]); end
    tests++; if (seq_a[2] !== 16'd110 || seq_b[2] !== 16'd20) begin fails++; $display("FAIL vec2: got %0d/%0d expected 110/20", seq_a[2], seq_b[2]); end
    tests++; if (seq_a[3] !== 16'hACE1 || seq_b[3] !== 16'h59C3) begin fails++; $display("FAIL vec3: got %0h/%0h expected ace1/59c3", seq_a[3], seq_b[3]); end
    tests++; if (seq_a[4] !== 16'hB387 || seq_b[4] !== 16'h670F) begin fails++; $display("FAIL vec4: got %0h/%0h expected b387/670f", seq_a[4], seq_b[4]); end
    tests++; if (a16 !== exp_a[15] || b16 !== exp_b[15]) begin fails++; $display("FAIL idle_hold_ab: got %0h/%0h expected %0h/%0h", a16, b16, exp_a[15], exp_b[15]); end
  endtask

  task automatic test_second_start();
    int dc, p;
    run16(10, 0, dc, p);
    tests++; if (dc !== 49) begin fails++; $display("FAIL restart_ignored_done: got %0d expected 49", dc); end
    tests++; if (p !== 1) begin fails++; $display("FAIL restart_ignored_pulses: got %0d expected 1", p); end
  endtask

  task automatic test_reset_mid_run();
    int dc, p, bad;
    run16(0, 20, dc, p);
    bad = 0;
    for (int k = 0; k < 6; k++) if (seq_a[k] !== exp_a[k] || seq_b[k] !== exp_b[k]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL abort_partial_seq: got %0d bad vectors expected 0", bad); end
    tests++; if (busy16 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy16); end
    tests++; if (dc !== -1 || done16 !== 1'b0) begin fails++; $display("FAIL abort_done: got cycle %0d expected none", dc); end
    tests++; if (fc16 !== 8'd0 || ffi16 !== 10'h3FF || pass16 !== 1'b0) begin fails++; $display("FAIL abort_results: got %0d/%0h/%b expected 0/3ff/0", fc16, ffi16, pass16); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin seq_a[k] = 16'hxxxx; seq_b[k] = 16'hxxxx; end
    run16(0, 0, dc, p);
    bad = 0;
    for (int k = 0; k < 16; k++) if (seq_a[k] !== exp_a[k] || seq_b[k] !== exp_b[k]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL rerun_sequence: got %0d bad vectors expected 0", bad); end
    tests++; if (dc !== 49 || pass16 !== 1'b1) begin fails++; $display("FAIL rerun_done: got cycle %0d pass %b expected 49/1", dc, pass16); end
  endtask

  task automatic test_eq_lt_both();
    int dc, p;
    mode16 = 3;
    run16(0, 0, dc, p);
    mode16 = 0;
    tests++; if (fc16 !== 8'd1) begin fails++; $display("FAIL eqlt_fail_count: got %0d expected 1", fc16); end
    tests++; if (ffi16 !== 10'd0) begin fails++; $display("FAIL eqlt_first_fail: got %0d expected 0", ffi16); end
    tests++; if (pass16 !== 1'b0) begin fails++; $display("FAIL eqlt_pass: got %b expected 0", pass16); end
  endtask

  task automatic test_gt_stuck();
    int seen;
    seen = -1;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done3 === 1'b1 && seen < 0) seen = cyc;
    end
    tests++; if (seen !== 10) begin fails++; $display("FAIL n3_done_cycle: got %0d expected 10", seen); end
    tests++; if (fc3 !== 8'd1) begin fails++; $display("FAIL n3_fail_count: got %0d expected 1", fc3); end
    tests++; if (ffi3 !== 10'd2) begin fails++; $display("FAIL n3_first_fail: got %0d expected 2", ffi3); end
    tests++; if (pass3 !== 1'b0) begin fails++; $display("FAIL n3_pass: got %b expected 0", pass3); end
  endtask

  task automatic test_all_stuck();
    int seen;
    seen = -1;
    @(negedge clk); start300 = 1'b1;
    @(negedge clk); start300 = 1'b0;
    for (int cyc = 1; cyc <= 920; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done300 === 1'b1 && seen < 0) seen = cyc;
    end
    tests++; if (seen !== 901) begin fails++; $display("FAIL n300_done_cycle: got %0d expected 901", seen); end
    tests++; if (fc300 !== 8'd255) begin fails++; $display("FAIL n300_saturate: got %0d expected 255", fc300); end
    tests++; if (ffi300 !== 10'd0) begin fails++; $display("FAIL n300_first_fail: got %0d expected 0", ffi300); end
    tests++; if (pass300 !== 1'b0) begin fails++; $display("FAIL n300_pass: got %b expected 0", pass300); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic busy50, pass50, busy51, pass51;
    d1 = -1; d2 = -1;
    busy50 = 1'bx; pass50 = 1'bx; busy51 = 1'bx; pass51 = 1'bx;
    mode16 = 0;
    @(negedge clk); start16 = 1'b1;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(negedge clk);
      if (cyc == 50) begin busy50 = busy16; pass50 = pass16; end
      if (cyc == 51) begin busy51 = busy16; pass51 = pass16; start16 = 1'b0; end
      if (done16 === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
    end
    tests++; if (d1 !== 49) begin fails++; $display("FAIL b2b_first_done: got %0d expected 49", d1); end
    tests++; if (busy50 !== 1'b0 || pass50 !== 1'b1) begin fails++; $display("FAIL b2b_idle_gap: got busy %b pass %b expected 0/1", busy50, pass50); end
    tests++; if (busy51 !== 1'b1 || pass51 !== 1'b0) begin fails++; $display("FAIL b2b_restart: got busy %b pass %b expected 1/0", busy51, pass51); end
    tests++; if (d2 !== 99 || pass16 !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %0d pass %b expected 99/1", d2, pass16); end
  endtask

  initial begin
    logic [15:0] s;
    exp_a[0] = 16'd10;  exp_b[0] = 16'd20;
    exp_a[1] = 16'd100; exp_b[1] = 16'd100;
    exp_a[2] = 16'd110; exp_b[2] = 16'd20;
    s = 16'hACE1;
    for (int k = 3; k < 16; k++) begin
      exp_a[k] = s;
      exp_b[k] = ref_step(s);
      s = ref_step(exp_b[k]);
    end
    test_reset();
    test_first_start();
    test_ideal_run();
    test_second_start();
    test_reset_mid_run();
    test_eq_lt_both();
    test_gt_stuck();
    test_all_stuck();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
